// File: rtl/toggle_bank_ctrl.sv
// rtl/toggle_bank_ctrl.sv - one-shot up/down counter sequencer for an external toggle flip-flop bank
// Presets the bank by toggling, steps it to a target and cross-checks it against a shadow count.
module toggle_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             bank_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic             mode_r;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] exp_r;

  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] fin_val;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic             mismatch;
  logic             at_fin;

  assign init_val   = mode_r ? lim_r : '0;
  assign fin_val    = mode_r ? '0 : lim_r;
  assign mismatch   = (q != exp_r);
  assign at_fin     = (q == fin_val);
  assign busy       = (state != S_IDLE);
  assign bank_rst_n = ~rst;

  // Ripple-carry / ripple-borrow toggle masks: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c    = 1'b1;
    dn_c    = 1'b1;
    up_mask = '0;
    dn_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_mask[i] = up_c;
      dn_mask[i] = dn_c;
      up_c       = up_c & q[i];
      dn_c       = dn_c & ~q[i];
    end
  end

  always_comb begin
    t = '0;
    if (!rst) begin
      case (state)
        S_PREP: begin
          if (!stop) t = q ^ init_val;
        end
        S_RUN: begin
          if (!stop && !mismatch && !at_fin) t = mode_r ? dn_mask : up_mask;
        end
        default: t = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_r <= 1'b0;
      lim_r  <= '0;
      exp_r  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            mode_r <= mode;
            lim_r  <= limit;
            err    <= 1'b0;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          if (stop) begin
            state <= S_IDLE;
          end else begin
            exp_r <= init_val;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (mismatch) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (at_fin) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            exp_r <= mode_r ? (exp_r - ONE) : (exp_r + ONE);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_bank_ctrl.sv
// tb/tb_toggle_bank_ctrl.sv - directed bench for toggle_bank_ctrl with a toggle-bank model and per-cycle reference
module tb_toggle_bank_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop, mode;
  logic [W-1:0] limit;
  logic [W-1:0] q, t;
  logic         bank_rst_n, busy, done, err;

  logic [W-1:0] bank;
  logic         force_en;
  logic [W-1:0] force_val;

  int n_vec = 0;
  int n_bad = 0;

  toggle_bank_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .limit(limit),
    .q(q), .t(t), .bank_rst_n(bank_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // The external toggle flip-flop bank, with a fault-injection override on its outputs.
  always_ff @(posedge clk) begin
    if (!bank_rst_n) bank <= '0;
    else             bank <= bank ^ t;
  end
  assign q = force_en ? force_val : bank;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: a run is "prep" then a walk of the expected bank value from init toward fin.
  logic         m_busy = 1'b0, m_prep = 1'b0, m_mode = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_lim = '0, m_cnt = '0;

  initial begin
    forever begin
      logic [W-1:0] qv, m_init, m_fin, exp_t;
      @(negedge clk);
      qv     = q;
      m_init = m_mode ? m_lim : '0;
      m_fin  = m_mode ? '0 : m_lim;
      exp_t  = '0;
      if (!rst && m_busy && !stop) begin
        if (m_prep) exp_t = qv ^ m_init;
        else if (qv == m_cnt && qv != m_fin) exp_t = m_mode ? (qv ^ (qv - 1'b1)) : (qv ^ (qv + 1'b1));
      end
      chk("model t", t, exp_t);
      chk("model busy", busy, m_busy);
      chk("model done", done, m_done);
      chk("model err", err, m_err);
      chk("model bank_rst_n", bank_rst_n, !rst);
      if (rst) begin
        m_busy = 0; m_prep = 0; m_mode = 0; m_done = 0; m_err = 0; m_lim = '0; m_cnt = '0;
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (start && !stop) begin
            m_mode = mode; m_lim = limit; m_err = 0; m_busy = 1; m_prep = 1;
          end
        end else if (m_prep) begin
          if (stop) m_busy = 0;
          else begin m_prep = 0; m_cnt = m_init; end
        end else begin
          if (stop) m_busy = 0;
          else if (qv != m_cnt) begin m_err = 1; m_busy = 0; end
          else if (qv == m_fin) begin m_done = 1; m_busy = 0; end
          else m_cnt = m_mode ? m_cnt - 1'b1 : m_cnt + 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen; k counts edges after E0.
  task automatic wait_done(input int k_now, input int k_exp, input string nm);
    int  k;
    bit  seen;
    k    = k_now;
    seen = 0;
    while (k < 60 && !seen) begin
      tick();
      k++;
      if (done === 1'b1) seen = 1;
    end
    chk({nm, " done edge"}, seen ? k : -1, k_exp);
  endtask

  task automatic begin_run(input logic md, input logic [W-1:0] lim);
    start = 1; mode = md; limit = lim;
    tick();
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; mode = 0; limit = '0; force_en = 0; force_val = '0;
    tick(); tick();
    chk("reset t", t, 4'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset bank_rst_n", bank_rst_n, 1'b0);
    rst = 0;
    #1 chk("released bank_rst_n", bank_rst_n, 1'b1);

    // Up count 0 -> 5
    begin_run(1'b0, 4'd5);
    chk("up prep busy", busy, 1'b1);
    chk("up prep t", t, 4'h0);
    repeat (4) tick();
    chk("up q at k4", q, 4'd3);
    chk("up t at q3", t, 4'b0111);
    wait_done(4, 7, "up5");
    chk("up5 err", err, 1'b0);
    chk("up5 final q", q, 4'd5);

    // Dirty the bank to 9, then count down from 12
    begin_run(1'b0, 4'd9);
    wait_done(0, 11, "pre9");
    chk("bank at 9", q, 4'd9);
    start = 1; mode = 1; limit = 4'd12;
    tick();
    start = 0;
    chk("down prep t", t, 4'b0101);
    tick();
    chk("down q after E1", q, 4'd12);
    wait_done(1, 14, "down12");
    chk("down final q", q, 4'd0);

    // limit 0 up, then back-to-back limit 0 down with start held
    start = 1; mode = 0; limit = 4'd0;
    tick();
    wait_done(0, 2, "up0");
    mode = 1;
    tick();
    chk("rearm busy", busy, 1'b1);
    start = 0;
    wait_done(0, 2, "down0");

    // Full range up, no wrap
    begin_run(1'b0, 4'd15);
    wait_done(0, 17, "up15");
    chk("up15 final q", q, 4'd15);
    chk("up15 err", err, 1'b0);

    // Abort in RUN at q=3
    begin_run(1'b0, 4'd9);
    repeat (4) tick();
    chk("abort q", q, 4'd3);
    stop = 1;
    #1 chk("abort t", t, 4'h0);
    tick();
    stop = 0;
    chk("abort busy", busy, 1'b0);
    chk("abort q hold", q, 4'd3);
    repeat (3) tick();
    chk("abort no done", done, 1'b0);

    // start with stop in IDLE
    start = 1; stop = 1;
    tick();
    chk("start+stop busy", busy, 1'b0);
    start = 0; stop = 0;

    // Fault at exp_r=2
    begin_run(1'b0, 4'd9);
    repeat (3) tick();
    chk("fault pre q", q, 4'd2);
    force_en = 1; force_val = 4'd6;
    #1 chk("fault t", t, 4'h0);
    tick();
    force_en = 0;
    chk("fault err", err, 1'b1);
    chk("fault busy", busy, 1'b0);
    repeat (3) tick();
    chk("fault err sticky", err, 1'b1);
    chk("fault no done", done, 1'b0);

    // New start clears err; then reset mid-run at q=4
    begin_run(1'b0, 4'd6);
    chk("start clears err", err, 1'b0);
    repeat (5) tick();
    chk("rst pre q", q, 4'd4);
    rst = 1; start = 1;
    #1 chk("rst cycle t", t, 4'h0);
    tick();
    chk("rst q", q, 4'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst done", done, 1'b0);
    tick();
    chk("start ignored in rst", busy, 1'b0);
    rst = 0; start = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
